// File: rtl/mvm_batch_ctrl.sv
// Batch MVM read-address sequencer: walks b (vector), r (matrix row), w (word)
// for a batch of vectors that all share one matrix block, and delays the
// per-element control flags by RD_LAT cycles so they line up with read data.
module mvm_batch_ctrl #(
    parameter int VEC_ADDRW = 8,
    parameter int MAT_ADDRW = 9,
    parameter int VEC_SIZEW = VEC_ADDRW + 1,
    parameter int MAT_SIZEW = MAT_ADDRW + 1,
    parameter int BATCHW    = 4,
    parameter int RD_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 start_ready,
    input  logic [VEC_ADDRW-1:0] vec_start_addr,
    input  logic [VEC_SIZEW-1:0] vec_num_words,
    input  logic [MAT_ADDRW-1:0] mat_start_addr,
    input  logic [MAT_SIZEW-1:0] mat_num_rows_per_olane,
    input  logic [BATCHW-1:0]    num_vecs,
    input  logic                 stall,
    output logic [VEC_ADDRW-1:0] vec_raddr,
    output logic [MAT_ADDRW-1:0] mat_raddr,
    output logic                 accum_first,
    output logic                 accum_last,
    output logic                 ovalid,
    output logic [BATCHW-1:0]    vec_idx,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [VEC_SIZEW-1:0] W_ONE = VEC_SIZEW'(1);
    localparam logic [MAT_SIZEW-1:0] R_ONE = MAT_SIZEW'(1);
    localparam logic [BATCHW-1:0]    B_ONE = BATCHW'(1);

    state_t               state_q, state_d;
    logic [VEC_ADDRW-1:0] vec_raddr_q, vec_raddr_d;
    logic [MAT_ADDRW-1:0] mat_raddr_q, mat_raddr_d;
    logic [VEC_ADDRW-1:0] vec_base_q, vec_base_d;
    logic [MAT_ADDRW-1:0] mat_base_q, mat_base_d;
    logic [MAT_ADDRW-1:0] mat_start_q, mat_start_d;
    logic [VEC_SIZEW-1:0] w_num_q, w_num_d;
    logic [MAT_SIZEW-1:0] r_num_q, r_num_d;
    logic [BATCHW-1:0]    b_num_q, b_num_d;
    logic [VEC_SIZEW-1:0] w_cnt_q, w_cnt_d;
    logic [MAT_SIZEW-1:0] r_cnt_q, r_cnt_d;
    logic [BATCHW-1:0]    b_cnt_q, b_cnt_d;
    logic                 degen_done_q, degen_done_d;

    logic [RD_LAT-1:0]              pv_q, pv_d;
    logic [RD_LAT-1:0]              pf_q, pf_d;
    logic [RD_LAT-1:0]              pl_q, pl_d;
    logic [RD_LAT-1:0]              pfin_q, pfin_d;
    logic [RD_LAT-1:0][BATCHW-1:0]  pidx_q, pidx_d;

    logic                 issue;
    logic                 w_last, r_last, b_last;
    logic                 degenerate;
    logic [VEC_ADDRW-1:0] vec_step;
    logic [MAT_ADDRW-1:0] mat_step;

    // Loop-position decode and the per-vector / per-row address strides
    always_comb begin
        issue      = (state_q == RUN) && !stall;
        w_last     = (w_cnt_q == (w_num_q - W_ONE));
        r_last     = (r_cnt_q == (r_num_q - R_ONE));
        b_last     = (b_cnt_q == (b_num_q - B_ONE));
        degenerate = (vec_num_words == '0) || (mat_num_rows_per_olane == '0) || (num_vecs == '0);
        vec_step   = VEC_ADDRW'(w_num_q);
        mat_step   = MAT_ADDRW'(w_num_q);
    end

    // Next-state logic: job acceptance, nested b/r/w stepping of the address registers, drain exit
    always_comb begin
        state_d      = state_q;
        vec_raddr_d  = vec_raddr_q;
        mat_raddr_d  = mat_raddr_q;
        vec_base_d   = vec_base_q;
        mat_base_d   = mat_base_q;
        mat_start_d  = mat_start_q;
        w_num_d      = w_num_q;
        r_num_d      = r_num_q;
        b_num_d      = b_num_q;
        w_cnt_d      = w_cnt_q;
        r_cnt_d      = r_cnt_q;
        b_cnt_d      = b_cnt_q;
        degen_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    w_num_d     = vec_num_words;
                    r_num_d     = mat_num_rows_per_olane;
                    b_num_d     = num_vecs;
                    mat_start_d = mat_start_addr;
                    w_cnt_d     = '0;
                    r_cnt_d     = '0;
                    b_cnt_d     = '0;
                    if (degenerate) begin
                        degen_done_d = 1'b1;
                    end else begin
                        state_d     = RUN;
                        vec_raddr_d = vec_start_addr;
                        vec_base_d  = vec_start_addr;
                        mat_raddr_d = mat_start_addr;
                        mat_base_d  = mat_start_addr;
                    end
                end
            end
            RUN: begin
                if (!stall) begin
                    if (!w_last) begin
                        w_cnt_d     = w_cnt_q + W_ONE;
                        vec_raddr_d = vec_raddr_q + VEC_ADDRW'(1);
                        mat_raddr_d = mat_raddr_q + MAT_ADDRW'(1);
                    end else begin
                        w_cnt_d = '0;
                        if (!r_last) begin
                            r_cnt_d     = r_cnt_q + R_ONE;
                            mat_base_d  = mat_base_q + mat_step;
                            mat_raddr_d = mat_base_q + mat_step;
                            vec_raddr_d = vec_base_q;
                        end else begin
                            r_cnt_d     = '0;
                            mat_base_d  = mat_start_q;
                            mat_raddr_d = mat_start_q;
                            if (!b_last) begin
                                b_cnt_d     = b_cnt_q + B_ONE;
                                vec_base_d  = vec_base_q + vec_step;
                                vec_raddr_d = vec_base_q + vec_step;
                            end else begin
                                state_d = DRAIN;
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                if (pv_q[RD_LAT-1] && pfin_q[RD_LAT-1]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control delay line: stage 0 captures the issuing element (or a bubble), later stages shift
    always_comb begin
        pv_d      = pv_q;
        pf_d      = pf_q;
        pl_d      = pl_q;
        pfin_d    = pfin_q;
        pidx_d    = pidx_q;
        pv_d[0]   = issue;
        pf_d[0]   = issue && (w_cnt_q == '0);
        pl_d[0]   = issue && w_last;
        pfin_d[0] = issue && w_last && r_last && b_last;
        pidx_d[0] = issue ? b_cnt_q : '0;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i]   = pv_q[i-1];
            pf_d[i]   = pf_q[i-1];
            pl_d[i]   = pl_q[i-1];
            pfin_d[i] = pfin_q[i-1];
            pidx_d[i] = pidx_q[i-1];
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            vec_raddr_q  <= '0;
            mat_raddr_q  <= '0;
            vec_base_q   <= '0;
            mat_base_q   <= '0;
            mat_start_q  <= '0;
            w_num_q      <= '0;
            r_num_q      <= '0;
            b_num_q      <= '0;
            w_cnt_q      <= '0;
            r_cnt_q      <= '0;
            b_cnt_q      <= '0;
            degen_done_q <= 1'b0;
            pv_q         <= '0;
            pf_q         <= '0;
            pl_q         <= '0;
            pfin_q       <= '0;
            pidx_q       <= '0;
        end else begin
            state_q      <= state_d;
            vec_raddr_q  <= vec_raddr_d;
            mat_raddr_q  <= mat_raddr_d;
            vec_base_q   <= vec_base_d;
            mat_base_q   <= mat_base_d;
            mat_start_q  <= mat_start_d;
            w_num_q      <= w_num_d;
            r_num_q      <= r_num_d;
            b_num_q      <= b_num_d;
            w_cnt_q      <= w_cnt_d;
            r_cnt_q      <= r_cnt_d;
            b_cnt_q      <= b_cnt_d;
            degen_done_q <= degen_done_d;
            pv_q         <= pv_d;
            pf_q         <= pf_d;
            pl_q         <= pl_d;
            pfin_q       <= pfin_d;
            pidx_q       <= pidx_d;
        end
    end

    assign vec_raddr   = vec_raddr_q;
    assign mat_raddr   = mat_raddr_q;
    assign ovalid      = pv_q[RD_LAT-1];
    assign accum_first = pf_q[RD_LAT-1];
    assign accum_last  = pl_q[RD_LAT-1];
    assign vec_idx     = pidx_q[RD_LAT-1];
    assign busy        = (state_q != IDLE);
    assign start_ready = (state_q == IDLE);
    assign done        = degen_done_q || (pv_q[RD_LAT-1] && pfin_q[RD_LAT-1]);

endmodule

// File: doc/mvm_batch_ctrl.md
Name: mvm_batch_ctrl

Overview:
Parametrised successor to the single-vector MVM control FSM. It sequences vector-memory and matrix-memory read addresses for a batch of up to 2^BATCHW-1 input vectors, reusing the same matrix block for each vector. It supports downstream stall (backpressure) and a parametrised memory read latency, and it issues start/ready and done handshakes. It sits between the host/instruction front end and the MVM datapath (vector/matrix RAMs feeding the dot-product lanes and accumulators).

Parameters:
VEC_ADDRW, 8, vector memory address width
MAT_ADDRW, 9, matrix memory address width
VEC_SIZEW, VEC_ADDRW+1, width of vec_num_words
MAT_SIZEW, MAT_ADDRW+1, width of mat_num_rows_per_olane
BATCHW, 4, width of num_vecs
RD_LAT, 2, cycles from address presented to read data valid (legal range 1..8)

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  reset; synchronous, active-low (0 = reset)
start  in  1  request to start a job; accepted only when start_ready=1
start_ready  out  1  high in IDLE only
vec_start_addr  in  VEC_ADDRW  base address of vector 0
vec_num_words  in  VEC_SIZEW  words per vector (W); also the matrix row length
mat_start_addr  in  MAT_ADDRW  base address of matrix row 0
mat_num_rows_per_olane  in  MAT_SIZEW  rows per output lane (R)
num_vecs  in  BATCHW  vectors in batch (B)
stall  in  1  downstream backpressure; freezes the issue stage
vec_raddr  out  VEC_ADDRW  vector read address
mat_raddr  out  MAT_ADDRW  matrix read address
accum_first  out  1  first word of a dot product; aligned to data
accum_last  out  1  last word of a dot product; aligned to data
ovalid  out  1  read data valid this cycle
vec_idx  out  BATCHW  batch index of the element flagged by ovalid
busy  out  1  job in progress, including pipeline drain
done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset (rst=0 at an edge): state=IDLE; all outputs 0 except start_ready=1; delay pipeline cleared. Reset overrides everything, including mid-job.
- States and transitions:
  - IDLE -> RUN on start & start_ready.
  - RUN -> DRAIN after the final element issues.
  - DRAIN -> IDLE once RD_LAT pipeline stages are empty.
- Start accept: handshake occurs at cycle T. All inputs are latched at T; later input changes are ignored.
- Element order: b = 0..B-1 (outer), r = 0..R-1, w = 0..W-1 (inner).
  - vec_raddr = vec_start_addr + b*W + w
  - mat_raddr = mat_start_addr + r*W + w
  - Addresses are generated with incrementing base registers; no multipliers. Addresses wrap modulo 2^ADDRW.
- Issue timing:
  - The first element's addresses are registered and visible at T+1.
  - In each RUN cycle t with stall=0, the current element issues and the next addresses appear at t+1.
  - With stall=1, addresses and counters hold and a bubble enters the pipeline.
- Control pipeline: for each element issued at cycle t, the following are driven at cycle t+RD_LAT (RD_LAT register stages):
  - ovalid=1
  - accum_first = (w==0)
  - accum_last = (w==W-1); first and last are both 1 when W=1
  - vec_idx = b
  - Bubbles give ovalid=accum_first=accum_last=0.
- busy: high from T+1 until the cycle after the final ovalid.
- done: pulses with the final ovalid, i.e. together with the accum_last of element (B-1, R-1, W-1).
- start_ready: 0 from T+1 until the state returns to IDLE. start is ignored while busy.
- Degenerate job (W=0, R=0 or B=0): accepted; no elements issued; ovalid never rises; done pulses at T+1; busy stays 0; state returns to IDLE at T+1.
- Stall held during DRAIN has no effect; the pipeline keeps draining. Stall in IDLE is ignored.
- Back-to-back jobs: a new start may be accepted in the first IDLE cycle after done.

Test Plan:
1. Reset and basic job: rst=0 for 2 cycles, then vec_start=0x10, W=3, mat_start=0x20, R=2, B=1, RD_LAT=2, no stall.
   -> vec_raddr 10,11,12,10,11,12; mat_raddr 20,21,22,23,24,25 at T+1..T+6.
   -> ovalid at T+3..T+8; accum_first at T+3 and T+6; accum_last at T+5 and T+8.
   -> done at T+8; busy 1 over T+1..T+8.
2. Batch: W=2, R=2, B=3, vec_start=0, mat_start=0.
   -> vec_raddr sequence 0,1,0,1,2,3,2,3,4,5,4,5; mat_raddr 0,1,2,3 repeated 3 times.
   -> vec_idx 0,0,0,0,1,... at ovalid; 6 accum_last pulses; done once.
3. Stall: job as in scenario 1 with stall=1 at T+2 and T+3.
   -> vec_raddr holds 0x11 for 3 cycles; ovalid low at T+4 and T+5.
   -> addresses resume in order; done at T+10.
4. W=1, R=3, B=1.
   -> accum_first=accum_last=1 on every ovalid (3 cycles); mat_raddr mat_start+0,1,2.
5. Degenerate and overlap: start with R=0 -> done at T+1, no ovalid, busy 0. Then start pulsed mid-job -> ignored (start_ready=0); no address perturbation.
6. Reset mid-job: rst=0 during RUN of scenario 2.
   -> next edge: ovalid=busy=done=0, start_ready=1.
   -> a new job after rst=1 runs cleanly from its own start addresses.
